// File: rtl/mer_meas_pkg.sv
// mer_meas_pkg: shared state encoding and default saturation limits for the MER sequencer
package mer_meas_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, ACCUM = 2'd2, DONE = 2'd3} state_t;
  localparam int DEF_ACC_W = 48;
  localparam int DEF_CNT_W = 24;
  localparam logic [DEF_ACC_W-1:0] DEF_ACC_MAX = {DEF_ACC_W{1'b1}};
  localparam logic [DEF_CNT_W-1:0] DEF_CNT_MAX = {DEF_CNT_W{1'b1}};
endpackage

// File: rtl/mer_measurement_sequencer_sat_accumulator.sv
// sat_accumulator: saturating unsigned accumulator with sticky saturation flag
//   clk, reset (async active-low), clr (sync clear), en (add din), din, acc (total), sat (sticky)
module sat_accumulator #(
  parameter int IN_W  = 36,
  parameter int ACC_W = 48
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [IN_W-1:0]  din,
  output logic [ACC_W-1:0] acc,
  output logic             sat
);
  // one guard bit above the wider operand so any carry past ACC_W is visible
  localparam int SW = (IN_W > ACC_W ? IN_W : ACC_W) + 1;
  logic [SW-1:0] w_sum;
  logic          w_ovf;
  assign w_sum = SW'(acc) + SW'(din);
  assign w_ovf = |w_sum[SW-1:ACC_W];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
      sat <= 1'b0;
    end else if (clr) begin
      acc <= '0;
      sat <= 1'b0;
    end else if (en) begin
      acc <= w_ovf ? '1 : w_sum[ACC_W-1:0];
      sat <= sat | w_ovf;
    end
  end
endmodule

// File: rtl/mer_measurement_sequencer.sv
// mer_measurement_sequencer: LFSR-period-aligned error/reference power accumulation for MER
//   in : clk, reset (async active-low), sym_clk_en, start, abort, cycle_pulse, err_sq, ref_sq
//   out: busy, acc_active, err_acc, ref_acc, sym_count, overflow, result_valid
module mer_measurement_sequencer
  import mer_meas_pkg::*;
#(
  parameter int SQ_W    = 36,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int WINDOWS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sym_clk_en,
  input  logic             start,
  input  logic             abort,
  input  logic             cycle_pulse,
  input  logic [SQ_W-1:0]  err_sq,
  input  logic [SQ_W-1:0]  ref_sq,
  output logic             busy,
  output logic             acc_active,
  output logic [ACC_W-1:0] err_acc,
  output logic [ACC_W-1:0] ref_acc,
  output logic [CNT_W-1:0] sym_count,
  output logic             overflow,
  output logic             result_valid
);
  localparam int WIN_W = $clog2(WINDOWS + 1);
  state_t           r_state;
  logic [WIN_W-1:0] r_win;
  logic             w_qual, w_last, w_clr, w_err_sat, w_ref_sat;
  assign w_qual = sym_clk_en & cycle_pulse;
  // the boundary that closes the final window ends the measurement and is not summed
  assign w_last = (r_state == ACCUM) && w_qual && (r_win == WIN_W'(1));
  assign w_clr  = abort || (start && (r_state == IDLE || r_state == DONE));
  assign acc_active = !abort && sym_clk_en &&
                      ((r_state == ARM && cycle_pulse) || (r_state == ACCUM && !w_last));
  assign overflow = w_err_sat | w_ref_sat;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_win        <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
    end else if (abort) begin
      r_state      <= IDLE;
      r_win        <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
    end else if (w_clr) begin
      r_state      <= ARM;
      busy         <= 1'b1;
      result_valid <= 1'b0;
    end else if (r_state == ARM && w_qual) begin
      r_state <= ACCUM;
      r_win   <= WIN_W'(WINDOWS);
    end else if (r_state == ACCUM && w_qual) begin
      r_win <= r_win - WIN_W'(1);
      if (w_last) begin
        r_state      <= DONE;
        busy         <= 1'b0;
        result_valid <= 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sym_count <= '0;
    else if (w_clr) sym_count <= '0;
    else if (acc_active && sym_count != '1) sym_count <= sym_count + CNT_W'(1);
  end
  sat_accumulator #(.IN_W(SQ_W), .ACC_W(ACC_W)) u_err (
    .clk(clk), .reset(reset), .clr(w_clr), .en(acc_active), .din(err_sq), .acc(err_acc), .sat(w_err_sat)
  );
  sat_accumulator #(.IN_W(SQ_W), .ACC_W(ACC_W)) u_ref (
    .clk(clk), .reset(reset), .clr(w_clr), .en(acc_active), .din(ref_sq), .acc(ref_acc), .sat(w_ref_sat)
  );
endmodule
